// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types for the ccff bitstream loader: loader FSM state encoding.
package ccff_bitstream_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/ccff_bitstream_loader_piso.sv
// Word-wide parallel-in/serial-out register with occupancy count; bit 0 leaves first.
module ccff_bitstream_loader_piso #(
    parameter int  WORD_W = 8,
    localparam int OCC_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_shift,
    input  logic              i_clear,
    output logic              o_bit,
    output logic [OCC_W-1:0]  o_occ,
    output logic              o_empty
);

    logic [WORD_W-1:0] r_sr;
    logic [OCC_W-1:0]  r_occ;

    // A load may coincide with the shift-out of the final held bit; the load wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_occ <= '0;
        end else if (i_load) begin
            r_sr  <= i_word;
            r_occ <= OCC_W'(WORD_W);
        end else if (i_clear) begin
            r_occ <= '0;
        end else if (i_shift) begin
            r_sr  <= r_sr >> 1;
            r_occ <= r_occ - 1'b1;
        end
    end

    assign o_bit   = r_sr[0];
    assign o_occ   = r_occ;
    assign o_empty = (r_occ == '0);

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words LSB-first into a ccff chain, exactly CHAIN_LEN bits per pass.
// Define CCFF_VERIFY_EN to enable the verify pass (ccff_tail compared against the re-sent stream).
module ccff_bitstream_loader
    import ccff_bitstream_loader_pkg::*;
#(
    parameter int  WORD_W    = 8,
    parameter int  CHAIN_LEN = 26,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [CNT_W-1:0]  mismatch_idx
);

    localparam int               OCC_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_done;
    logic             r_last_head;

    logic             w_piso_bit;
    logic             w_empty;
    logic [OCC_W-1:0] w_occ;
    logic             w_start;
    logic             w_shift;
    logic             w_last;
    logic             w_ready;
    logic             w_load;

    assign w_start = start && (r_state == ST_IDLE);
    assign w_shift = (r_state == ST_SHIFT) && !w_empty;
    assign w_last  = w_shift && (r_bit_cnt == LAST_IDX);
    // Refill while the final held bit is leaving keeps the stream bubble-free.
    assign w_ready = (r_state == ST_SHIFT) &&
                     (w_empty || ((w_occ == OCC_W'(1)) && (r_bit_cnt < LAST_IDX)));
    assign w_load  = w_ready && word_valid;

    ccff_bitstream_loader_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .clk     (prog_clk),
        .rst     (pReset),
        .i_load  (w_load),
        .i_word  (word_in),
        .i_shift (w_shift),
        .i_clear (w_last),
        .o_bit   (w_piso_bit),
        .o_occ   (w_occ),
        .o_empty (w_empty)
    );

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_done      <= 1'b0;
            r_last_head <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_shift) begin
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        r_last_head <= w_piso_bit;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign word_ready    = w_ready;
    assign ccff_shift_en = w_shift;
    assign ccff_head     = w_shift ? w_piso_bit : r_last_head;
    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;

`ifdef CCFF_VERIFY_EN
    logic             r_verify;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_mismatch_idx;

    // The tail carries the previous pass's bit i exactly when bit i of the re-sent stream enters.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_verify       <= 1'b0;
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= '0;
        end else if (w_start) begin
            r_verify       <= verify;
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= '0;
        end else if (w_shift && r_verify && !r_mismatch && (ccff_tail != w_piso_bit)) begin
            r_mismatch     <= 1'b1;
            r_mismatch_idx <= r_bit_cnt;
        end
    end

    assign mismatch     = r_mismatch;
    assign mismatch_idx = r_mismatch_idx;
`else
    logic w_unused;
    assign w_unused     = verify ^ ccff_tail;
    assign mismatch     = 1'b0;
    assign mismatch_idx = '0;
`endif

endmodule
